psum_acc_spad: RTL
==================

PSUM_ACC_SPAD -- requirements
Module: psum_acc_spad

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the psum word width.
REQ-002 The block SHALL have parameter DEPTH, default 24, giving the number of entries.
REQ-003 The block SHALL have parameter ADDR_W, default 5, giving the address width; ADDR_W >= clog2(DEPTH).
REQ-004 The block SHALL have parameter SAT, default 1, where 1 selects a saturating accumulate and 0 selects a wrapping accumulate.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port op_valid, input, 1 bit: an operation request is present.
REQ-008 The block SHALL have port op, input, 2 bits: 00 nop, 01 read, 10 write, 11 accumulate.
REQ-009 The block SHALL have port addr, input, ADDR_W bits: the entry address.
REQ-010 The block SHALL have port data_in, input, DATA_W bits: the write data or addend, signed two's complement.
REQ-011 The block SHALL have port op_ready, output, 1 bit: the block can accept an operation this cycle.
REQ-012 The block SHALL have port rd_valid, output, 1 bit: data_out holds a read result for one cycle.
REQ-013 The block SHALL have port data_out, output, DATA_W bits: the read result.
REQ-014 The block SHALL have port clr_start, input, 1 bit: a request to zero all entries.
REQ-015 The block SHALL have port clr_busy, output, 1 bit: a clear sweep is in progress.
REQ-016 The block SHALL have port err, output, 1 bit: a one-cycle pulse on an accepted out-of-range address.

Function
REQ-017 An operation SHALL be accepted on a rising edge where op_valid=1 and op_ready=1.
REQ-018 op_ready SHALL be the combinational value (state==IDLE && !clr_start).
REQ-019 A nop SHALL be accepted without any effect on the memory or the outputs.
REQ-020 An accepted write SHALL update mem[addr] with data_in at the accept edge.
REQ-021 An accepted read SHALL drive data_out=mem[addr] with rd_valid=1 during the cycle after the accept edge.
REQ-022 rd_valid SHALL be 0 in every cycle that does not follow an accepted read; data_out SHALL hold its last value while rd_valid=0.
REQ-023 Accumulate SHALL be a 2-stage pipeline: at the accept edge, stage S1 captures addr, data_in and the old value; at the next edge, mem[addr] <= old + data_in.
REQ-024 A new operation SHALL be acceptable every cycle, including back-to-back accumulates.
REQ-025 Forwarding: when S1 is valid and an accepted read, write or accumulate targets the same addr, the old value or read data SHALL be the S1 sum, not the memory contents.
REQ-026 Write while S1 is pending to the same addr: the S1 retire edge and the write edge are the same edge, and the write data SHALL win over the S1 sum.
REQ-027 Arithmetic with SAT=1: signed DATA_W add clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-028 Arithmetic with SAT=0: signed DATA_W add taken modulo 2^DATA_W.
REQ-029 An accepted op with addr >= DEPTH SHALL have no memory effect and SHALL pulse err=1 the following cycle.
REQ-030 An out-of-range read SHALL still pulse rd_valid, with data_out=0.
REQ-031 The block SHALL have FSM states IDLE and CLEAR.
REQ-032 In IDLE, clr_start=1 on an edge SHALL cause a transition to CLEAR, reset the counter to 0, and take priority over op_valid in the same cycle.
REQ-033 In CLEAR, the block SHALL write mem[cnt]=0 each edge and increment cnt; after writing DEPTH-1 it SHALL return to IDLE, for a total of DEPTH cycles in CLEAR.
REQ-034 clr_busy SHALL equal (state==CLEAR).
REQ-035 clr_start SHALL be ignored while in CLEAR.
REQ-036 An S1 entry pending when the clear is accepted SHALL retire normally at that edge and is then overwritten by the sweep.

Reset
REQ-037 rst_n=0 SHALL asynchronously force the following: state=IDLE, cnt=0, S1 invalid, rd_valid=0, data_out=0, err=0.
REQ-038 Memory contents SHALL NOT be reset and are undefined until written or cleared.
REQ-039 Reset mid-clear SHALL abort the sweep, with the remaining entries keeping their prior contents.
REQ-040 Reset with S1 pending SHALL discard the pending write.
REQ-041 After rst_n rises, op_ready SHALL be 1 in the first cycle.

Verification
REQ-042 Clear then read: clr_start, wait until clr_busy=0 (exactly 24 cycles), read addr 23 -> rd_valid=1, data_out=0x0000.
REQ-043 Back-to-back accumulate: write addr3=5, then accumulate addr3 +7, +7, +7 on consecutive cycles, then read addr3 -> data_out=26.
REQ-044 Saturation: with SAT=1, write 0x7FF0, accumulate +0x0100 -> read returns 0x7FFF; with SAT=0 -> 0x80F0.
REQ-045 Same-edge conflict: accumulate addr1 +4 followed the next cycle by a write to addr1 of 9 -> read addr1 returns 9.
REQ-046 Range error and priority: read addr 30 -> err pulse, rd_valid=1, data_out=0; clr_start and op_valid both high -> op_ready=0 and the op is not accepted.
REQ-047 Reset mid-clear: assert rst_n=0 at clear cycle 10 -> clr_busy=0 immediately; entries 10..23 keep their prior values.

Source files
------------

// File: rtl/psum_acc_spad.sv
// psum_acc_spad: partial-sum scratchpad with read, write, and pipelined
// saturating/wrapping accumulate, plus a one-entry-per-cycle clear sweep.
`default_nettype none

module psum_acc_spad #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 24,
    parameter int ADDR_W = 5,
    parameter int SAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic              op_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] data_out,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              err
);

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b10;
    localparam logic [1:0] OP_ACC = 2'b11;

    localparam logic [ADDR_W:0]   DEPTH_L = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LAST    = DEPTH_L[ADDR_W-1:0] - 1'b1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_old;
    logic [DATA_W-1:0] s1_data;

    logic              accept;
    logic              in_range;
    logic              hit;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W-1:0] s1_sum;
    logic [DATA_W-1:0] cur;

    assign op_ready = (state == IDLE) && !clr_start;
    assign clr_busy = (state == CLEAR);
    assign accept   = op_valid && op_ready;
    assign in_range = ({1'b0, addr} < DEPTH_L);
    assign hit      = s1_valid && (s1_addr == addr);

    // One extra bit catches signed overflow: the top two bits disagree.
    always_comb begin
        sum_ext = {s1_old[DATA_W-1], s1_old} + {s1_data[DATA_W-1], s1_data};
        s1_sum  = sum_ext[DATA_W-1:0];
        if ((SAT != 0) && (sum_ext[DATA_W] != sum_ext[DATA_W-1])) begin
            s1_sum = sum_ext[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                     : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    // The in-flight sum shadows memory for the same address.
    always_comb begin
        cur = '0;
        if (in_range) begin
            cur = hit ? s1_sum : mem[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_old   <= '0;
            s1_data  <= '0;
            rd_valid <= 1'b0;
            data_out <= '0;
            err      <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            err      <= 1'b0;
            s1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end else if (accept) begin
                        if (op != OP_NOP) begin
                            err <= !in_range;
                        end
                        if (op == OP_RD) begin
                            rd_valid <= 1'b1;
                            data_out <= cur;
                        end
                        if ((op == OP_ACC) && in_range) begin
                            s1_valid <= 1'b1;
                            s1_addr  <= addr;
                            s1_old   <= cur;
                            s1_data  <= data_in;
                        end
                    end
                end
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory is not reset; writes are gated while reset is held so an
    // aborted sweep or discarded accumulate leaves contents untouched.
    // A same-edge write is placed after the S1 retire so the write wins.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (s1_valid) begin
                mem[s1_addr] <= s1_sum;
            end
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end else if (accept && (op == OP_WR) && in_range) begin
                mem[addr] <= data_in;
            end
        end
    end

endmodule

`default_nettype wire
